// File: rtl/dlc_pkg.sv
// Shared types and defaults for the delay line controller.
// Request encoding and a decode helper for the phase-detector inputs.
package dlc_pkg;

    localparam int DLC_DEPTH    = 32;
    localparam int DLC_INIT_TAP = 16;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_INC  = 2'd1,
        REQ_DEC  = 2'd2
    } req_e;

    // Simultaneous left/right requests cancel and are treated as idle.
    function automatic req_e decode_req(input logic left, input logic right);
        if (left && !right) begin
            return REQ_INC;
        end
        if (right && !left) begin
            return REQ_DEC;
        end
        return REQ_NONE;
    endfunction

endpackage

// File: rtl/dlc_tap_pointer.sv
// Saturating tap pointer: a held request steps the tap once every STEP_DIV cycles.
// Latency: tap_sel moves on the edge that completes a step period; no backpressure.
module dlc_tap_pointer
    import dlc_pkg::*;
#(
    parameter int DEPTH    = DLC_DEPTH,
    parameter int INIT_TAP = DLC_INIT_TAP,
    parameter int STEP_DIV = 1,
    parameter int TAP_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_left,
    input  logic             shift_right,
    output logic [TAP_W-1:0] tap_sel,
    output logic             at_min,
    output logic             at_max
);

    localparam int               CNT_W    = $clog2(STEP_DIV + 1);
    localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    req_e             req;
    req_e             prev_req_q, prev_req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic             step_en;

    always_comb begin
        req        = decode_req(shift_left, shift_right);
        prev_req_d = req;
        // A direction change restarts the step period from this cycle.
        cnt_eff    = (req == prev_req_q) ? cnt_q : '0;
        cnt_d      = '0;
        step_en    = 1'b0;
        tap_d      = tap_q;

        if (req != REQ_NONE) begin
            if (cnt_eff == CNT_LAST) begin
                step_en = 1'b1;
            end else begin
                cnt_d = cnt_eff + CNT_W'(1);
            end
        end

        if (step_en) begin
            case (req)
                REQ_INC: if (tap_q != TAP_MAX) tap_d = tap_q + TAP_W'(1);
                REQ_DEC: if (tap_q != '0)      tap_d = tap_q - TAP_W'(1);
                default: tap_d = tap_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q      <= TAP_W'(INIT_TAP);
            cnt_q      <= '0;
            prev_req_q <= REQ_NONE;
        end else begin
            tap_q      <= tap_d;
            cnt_q      <= cnt_d;
            prev_req_q <= prev_req_d;
        end
    end

    assign tap_sel = tap_q;
    assign at_min  = (tap_q == '0);
    assign at_max  = (tap_q == TAP_MAX);

endmodule

// File: rtl/delay_line_controller.sv
// Variable delay line for CDR phase alignment: dout is din delayed by tap_sel+1 cycles.
// Tap changes may drop or repeat one bit (phase slip); no backpressure.
module delay_line_controller
    import dlc_pkg::*;
#(
    parameter int DEPTH    = DLC_DEPTH,
    parameter int INIT_TAP = DLC_INIT_TAP,
    parameter int STEP_DIV = 1,
    parameter int TAP_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             shift_right,
    input  logic             shift_left,
    output logic             dout,
    output logic [TAP_W-1:0] tap_sel,
    output logic             at_min,
    output logic             at_max
);

    logic [DEPTH-1:0] line_q, line_d;
    logic             dout_q, dout_d;

    dlc_tap_pointer #(
        .DEPTH    (DEPTH),
        .INIT_TAP (INIT_TAP),
        .STEP_DIV (STEP_DIV),
        .TAP_W    (TAP_W)
    ) u_tap_pointer (
        .clk         (clk),
        .rst         (rst),
        .shift_left  (shift_left),
        .shift_right (shift_right),
        .tap_sel     (tap_sel),
        .at_min      (at_min),
        .at_max      (at_max)
    );

    // The tap is read before this edge's pointer update takes effect.
    always_comb begin
        line_d = {line_q[DEPTH-2:0], din};
        dout_d = line_q[tap_sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
            dout_q <= 1'b0;
        end else begin
            line_q <= line_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_delay_line_controller.sv
// Self-checking bench: STEP_DIV=1 and STEP_DIV=4 instances share stimulus,
// each compared every cycle against an edge-indexed reference model.
module tb_delay_line_controller;

    localparam int DEPTH    = 32;
    localparam int INIT_TAP = 16;
    localparam int TAP_W    = 5;
    localparam int LOG_SZ   = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic shift_left = 1'b0;
    logic shift_right = 1'b0;

    logic             dout1, at_min1, at_max1;
    logic [TAP_W-1:0] tap1;
    logic             dout4, at_min4, at_max4;
    logic [TAP_W-1:0] tap4;

    int compared = 0;
    int mismatched = 0;

    delay_line_controller #(
        .DEPTH(DEPTH), .INIT_TAP(INIT_TAP), .STEP_DIV(1), .TAP_W(TAP_W)
    ) dut1 (
        .clk(clk), .rst(rst), .din(din),
        .shift_right(shift_right), .shift_left(shift_left),
        .dout(dout1), .tap_sel(tap1), .at_min(at_min1), .at_max(at_max1)
    );

    delay_line_controller #(
        .DEPTH(DEPTH), .INIT_TAP(INIT_TAP), .STEP_DIV(4), .TAP_W(TAP_W)
    ) dut4 (
        .clk(clk), .rst(rst), .din(din),
        .shift_right(shift_right), .shift_left(shift_left),
        .dout(dout4), .tap_sel(tap4), .at_min(at_min4), .at_max(at_max4)
    );

    always #5 clk = ~clk;

    // Reference model: din history indexed by edge number, tap as a clamped integer,
    // and the length of the current run of identical requests.
    bit din_log [0:LOG_SZ-1];
    int edge_n   = 0;
    int last_rst = 0;
    int m_tap [2];
    int m_run [2];
    int m_div [2] = '{1, 4};
    int m_prev = 0;
    logic m_dout [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_update(input logic d, input logic l, input logic r, input logic rs);
        int dir;
        int idx;
        edge_n++;
        if (rs) begin
            for (int m = 0; m < 2; m++) begin
                m_tap[m]  = INIT_TAP;
                m_run[m]  = 0;
                m_dout[m] = 1'b0;
            end
            m_prev   = 0;
            last_rst = edge_n;
        end else begin
            dir = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
            for (int m = 0; m < 2; m++) begin
                idx = edge_n - 1 - m_tap[m];
                m_dout[m] = (idx > last_rst) ? din_log[idx] : 1'b0;
                if (dir == 0) begin
                    m_run[m] = 0;
                end else begin
                    m_run[m] = (dir == m_prev) ? m_run[m] + 1 : 1;
                    if (m_run[m] % m_div[m] == 0) begin
                        if (dir == 1 && m_tap[m] < DEPTH - 1) m_tap[m]++;
                        if (dir == 2 && m_tap[m] > 0)         m_tap[m]--;
                    end
                end
            end
            din_log[edge_n] = d;
            m_prev = dir;
        end
    endtask

    task automatic step(input logic d, input logic l, input logic r, input logic rs);
        din = d;
        shift_left = l;
        shift_right = r;
        rst = rs;
        @(posedge clk);
        model_update(d, l, r, rs);
        #1;
        chk("dout_s1",   {31'd0, dout1},   {31'd0, m_dout[0]});
        chk("tap_s1",    {27'd0, tap1},    m_tap[0]);
        chk("min_s1",    {31'd0, at_min1}, (m_tap[0] == 0) ? 1 : 0);
        chk("max_s1",    {31'd0, at_max1}, (m_tap[0] == DEPTH - 1) ? 1 : 0);
        chk("dout_s4",   {31'd0, dout4},   {31'd0, m_dout[1]});
        chk("tap_s4",    {27'd0, tap4},    m_tap[1]);
        chk("min_s4",    {31'd0, at_min4}, (m_tap[1] == 0) ? 1 : 0);
        chk("max_s4",    {31'd0, at_max4}, (m_tap[1] == DEPTH - 1) ? 1 : 0);
    endtask

    initial begin
        logic [15:0] pat;
        int lat;
        logic rl, rr;

        // Reset held two cycles, then idle with din=0.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_tap",  {27'd0, tap1}, 16);
        chk("rst_dout", {31'd0, dout1}, 0);
        chk("rst_min",  {31'd0, at_min1}, 0);
        chk("rst_max",  {31'd0, at_max1}, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);

        // Single-bit pulse: dout must rise exactly 17 edges after the sampling edge.
        step(1, 0, 0, 0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 0, 0);
            if (dout1 === 1'b1 && lat == 0) lat = i;
        end
        chk("pulse_latency", lat, 17);

        pat = 16'b0001100001100101;
        for (int i = 15; i >= 0; i--) step(pat[i], 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);

        // Increase to saturation, then decrease to saturation, then both held.
        for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 1, 0, 0);
        chk("sat_max_tap", {27'd0, tap1}, 31);
        chk("sat_max_flag", {31'd0, at_max1}, 1);
        chk("div4_after20", {27'd0, tap4}, 21);
        for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 0, 1, 0);
        chk("sat_min_tap", {27'd0, tap1}, 0);
        chk("sat_min_flag", {31'd0, at_min1}, 1);
        for (int i = 0; i < 5; i++) step(1'($urandom_range(0, 1)), 1, 1, 0);
        chk("both_hold", {27'd0, tap1}, 0);

        // STEP_DIV=4: eight held cycles give two steps; a flip after three gives none.
        step(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1'($urandom_range(0, 1)), 1, 0, 0);
        chk("div4_two_steps", {27'd0, tap4}, 18);
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        chk("div4_flip_nostep", {27'd0, tap4}, 16);
        step(0, 0, 1, 0);
        chk("div4_flip_restart", {27'd0, tap4}, 15);

        // Reset while shift_left is held at tap 25.
        step(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 1, 0, 0);
        chk("pre_rst_tap", {27'd0, tap1}, 25);
        step(1, 1, 0, 1);
        chk("mid_rst_tap", {27'd0, tap1}, 16);
        chk("mid_rst_dout", {31'd0, dout1}, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);

        // Randomised run: held request bursts, random data, rare resets.
        rl = 1'b0;
        rr = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                rl = 1'($urandom_range(0, 1));
                rr = 1'($urandom_range(0, 1));
            end
            step(1'($urandom_range(0, 1)), rl, rr, ($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
